// File: rtl/eq_menu_ctrl_if.sv
// Gain-update handshake between the menu controller (master) and the DSP (slave).
interface eq_menu_ctrl_if #(
    parameter int BAND_W = 3,
    parameter int GAIN_W = 16
);
    logic              valid;
    logic [BAND_W-1:0] band;
    logic [GAIN_W-1:0] gain;
    logic              ready;

    modport master (output valid, band, gain, input ready);
    modport slave  (input valid, band, gain, output ready);
endinterface

// File: rtl/eq_menu_ctrl.sv
// Button-driven menu FSM for the N-band equaliser: init wait, band gains, offset, DSP reset.
// Optional preset slots (save/load with per-band update walk) under `EQ_PRESET_EN.
module eq_menu_ctrl #(
    parameter int N_BAND   = 8,
    parameter int GAIN_W   = 16,
    parameter int GAIN_MAX = 12,
    parameter int GAIN_MIN = -12,
    parameter int OFS_MAX  = 3,
    parameter int N_PRESET = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_select,
    input  logic                           i_back,
    input  logic                           i_up,
    input  logic                           i_down,
    input  logic                           i_init_done,
    output logic                           o_init_start,
    output logic [2:0]                     o_state,
    output logic [2:0]                     o_menu,
    output logic [$clog2(N_BAND)-1:0]      o_band,
    output logic [GAIN_W-1:0]              o_gain,
    output logic [$clog2(OFS_MAX+1)-1:0]   o_offset,
    output logic                           o_dsp_reset,
    eq_menu_ctrl_if.master                 upd
);

    localparam int BW = $clog2(N_BAND);
    localparam int OW = $clog2(OFS_MAX + 1);
    localparam logic [BW-1:0] BAND_LAST = BW'(N_BAND - 1);
    localparam logic [OW-1:0] OFS_TOP   = OW'(OFS_MAX);
    localparam logic signed [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
    localparam logic signed [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_MENU       = 3'd2,
        S_BAND_SEL   = 3'd3,
        S_SET_GAIN   = 3'd4,
        S_SET_OFFSET = 3'd5,
        S_RESET_DSP  = 3'd6,
        S_PRESET     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        M_EQ     = 3'd0,
        M_OFFSET = 3'd1,
        M_RESET  = 3'd2,
        M_LOAD   = 3'd3,
        M_SAVE   = 3'd4
    } menu_t;

`ifdef EQ_PRESET_EN
    localparam menu_t M_LAST = M_SAVE;
`else
    localparam menu_t M_LAST = M_RESET;
`endif

    state_t state, state_nx;
    menu_t  menu;
    logic [BW-1:0] band;
    logic [OW-1:0] offset;
    logic signed [GAIN_W-1:0] gain_mem [N_BAND];

    logic              upd_valid;
    logic [BW-1:0]     upd_band;
    logic [GAIN_W-1:0] upd_gain;

    logic btn_back, btn_sel, btn_up, btn_down;
    logic signed [GAIN_W-1:0] cur_gain, new_gain;
    logic gain_chg, dsp_clear;

`ifdef EQ_PRESET_EN
    localparam int SW = (N_PRESET > 1) ? $clog2(N_PRESET) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_PRESET - 1);

    logic signed [GAIN_W-1:0] slot_mem [N_PRESET][N_BAND];
    logic [SW-1:0] slot;
    logic [BW-1:0] walk;
    logic preset_save, load_busy;
    logic preset_idle, save_go, load_start, load_step, load_last;
`endif

    // Only the highest-priority pulse survives: back > select > up > down.
    always_comb begin
        btn_back  = i_back;
        btn_sel   = i_select & ~i_back;
        btn_up    = i_up & ~i_select & ~i_back;
        btn_down  = i_down & ~i_up & ~i_select & ~i_back;

        cur_gain  = gain_mem[band];
        new_gain  = btn_up ? cur_gain + 1'b1 : cur_gain - 1'b1;
        gain_chg  = (state == S_SET_GAIN) &&
                    ((btn_up && (cur_gain < G_MAX)) || (btn_down && (cur_gain > G_MIN)));
        dsp_clear = (state == S_MENU) && btn_sel && (menu == M_RESET);
`ifdef EQ_PRESET_EN
        preset_idle = (state == S_PRESET) && !load_busy;
        save_go     = preset_idle && btn_sel && preset_save;
        load_start  = preset_idle && btn_sel && !preset_save;
        load_step   = load_busy && upd_valid && upd.ready;
        load_last   = (walk == BAND_LAST);
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:       if (i_init_done) state_nx = S_IDLE;
            S_IDLE:       if (btn_sel) state_nx = S_MENU;
            S_MENU: begin
                if (btn_back) state_nx = S_IDLE;
                else if (btn_sel) begin
                    case (menu)
                        M_EQ:     state_nx = S_BAND_SEL;
                        M_OFFSET: state_nx = S_SET_OFFSET;
                        M_RESET:  state_nx = S_RESET_DSP;
`ifdef EQ_PRESET_EN
                        M_LOAD,
                        M_SAVE:   state_nx = S_PRESET;
`endif
                        default:  state_nx = S_MENU;
                    endcase
                end
            end
            S_BAND_SEL: begin
                if (btn_back)     state_nx = S_MENU;
                else if (btn_sel) state_nx = S_SET_GAIN;
            end
            S_SET_GAIN:   if (btn_back || btn_sel) state_nx = S_BAND_SEL;
            S_SET_OFFSET: if (btn_back || btn_sel) state_nx = S_MENU;
            S_RESET_DSP:  state_nx = S_MENU;
            S_PRESET: begin
`ifdef EQ_PRESET_EN
                if (load_busy) begin
                    if (load_step && load_last) state_nx = S_MENU;
                end else if (btn_back || save_go) begin
                    state_nx = S_MENU;
                end
`else
                state_nx = S_MENU;
`endif
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_comb begin
        o_init_start = (state == S_INIT);
        o_dsp_reset  = (state == S_RESET_DSP);
        o_state      = state;
        o_menu       = menu;
        o_gain       = cur_gain;
        o_offset     = offset;
`ifdef EQ_PRESET_EN
        o_band       = (state == S_PRESET) ? BW'(slot) : band;
`else
        o_band       = band;
`endif
        upd.valid    = upd_valid;
        upd.band     = upd_band;
        upd.gain     = upd_gain;
    end

    // Menu and offset move down the list on "down"; band and slot count up on "up".
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            menu   <= M_EQ;
            band   <= '0;
            offset <= '0;
        end else begin
            case (state)
                S_IDLE: if (btn_sel) menu <= M_EQ;
                S_MENU: begin
                    if (btn_sel && (menu == M_EQ))          band <= '0;
                    else if (dsp_clear)                     offset <= '0;
                    else if (btn_down && (menu != M_LAST))  menu <= menu_t'(menu + 3'd1);
                    else if (btn_up && (menu != M_EQ))      menu <= menu_t'(menu - 3'd1);
                end
                S_BAND_SEL: begin
                    if (btn_up && (band != BAND_LAST))      band <= band + 1'b1;
                    else if (btn_down && (band != '0))      band <= band - 1'b1;
                end
                S_SET_OFFSET: begin
                    if (btn_down && (offset != OFS_TOP))    offset <= offset + 1'b1;
                    else if (btn_up && (offset != '0))      offset <= offset - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned b = 0; b < N_BAND; b++) gain_mem[b] <= '0;
        end else if (dsp_clear) begin
            for (int unsigned b = 0; b < N_BAND; b++) gain_mem[b] <= '0;
        end else if (gain_chg) begin
            gain_mem[band] <= new_gain;
`ifdef EQ_PRESET_EN
        end else if (load_start) begin
            for (int unsigned b = 0; b < N_BAND; b++) gain_mem[b] <= slot_mem[slot][b];
`endif
        end
    end

    // A new change in the same cycle as a transfer reloads the payload and keeps valid high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            upd_valid <= 1'b0;
            upd_band  <= '0;
            upd_gain  <= '0;
        end else if (dsp_clear) begin
            upd_valid <= 1'b0;
        end else if (gain_chg) begin
            upd_valid <= 1'b1;
            upd_band  <= band;
            upd_gain  <= new_gain;
`ifdef EQ_PRESET_EN
        end else if (load_start) begin
            upd_valid <= 1'b1;
            upd_band  <= '0;
            upd_gain  <= slot_mem[slot][0];
        end else if (load_step && !load_last) begin
            upd_valid <= 1'b1;
            upd_band  <= walk + 1'b1;
            upd_gain  <= gain_mem[walk + 1'b1];
`endif
        end else if (upd_valid && upd.ready) begin
            upd_valid <= 1'b0;
        end
    end

`ifdef EQ_PRESET_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot        <= '0;
            walk        <= '0;
            preset_save <= 1'b0;
            load_busy   <= 1'b0;
            for (int unsigned p = 0; p < N_PRESET; p++)
                for (int unsigned b = 0; b < N_BAND; b++) slot_mem[p][b] <= '0;
        end else begin
            if ((state == S_MENU) && btn_sel && ((menu == M_LOAD) || (menu == M_SAVE)))
                preset_save <= (menu == M_SAVE);
            if (preset_idle) begin
                if (btn_up && (slot != SLOT_LAST))  slot <= slot + 1'b1;
                else if (btn_down && (slot != '0))  slot <= slot - 1'b1;
            end
            if (save_go)
                for (int unsigned b = 0; b < N_BAND; b++) slot_mem[slot][b] <= gain_mem[b];
            if (load_start) begin
                load_busy <= 1'b1;
                walk      <= '0;
            end else if (load_step) begin
                if (load_last) load_busy <= 1'b0;
                else           walk <= walk + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Directed, table-driven bench for eq_menu_ctrl plus hand sequences for the handshake corners.
module tb_eq_menu_ctrl;

    logic clk = 1'b0;
    logic rst, sel, back, up, down, init_done;
    logic        init_start, dsp_reset;
    logic [2:0]  state, menu, band;
    logic [15:0] gain;
    logic [1:0]  offset;

    eq_menu_ctrl_if #(.BAND_W(3), .GAIN_W(16)) upd ();

    eq_menu_ctrl #(
        .N_BAND(8), .GAIN_W(16), .GAIN_MAX(12), .GAIN_MIN(-12), .OFS_MAX(3), .N_PRESET(4)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_select(sel), .i_back(back), .i_up(up), .i_down(down),
        .i_init_done(init_done), .o_init_start(init_start), .o_state(state), .o_menu(menu),
        .o_band(band), .o_gain(gain), .o_offset(offset), .o_dsp_reset(dsp_reset), .upd(upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s, b, u, d, rdy;
        logic [2:0] st, mn, bd;
        logic [15:0] gn;
        logic [1:0] of;
        logic v, dsp;
    } vec_t;

    typedef struct {
        logic [2:0]  band;
        logic [15:0] gain;
    } xfer_t;

    vec_t  vecs[$];
    xfer_t xq[$];
    int passed = 0;
    int total  = 0;

    always @(negedge clk)
        if (!rst && upd.valid && upd.ready) xq.push_back('{upd.band, upd.gain});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input logic s, input logic b, input logic u, input logic d);
        sel = s; back = b; up = u; down = d;
        @(posedge clk);
        #1;
        sel = 1'b0; back = 1'b0; up = 1'b0; down = 1'b0;
    endtask

    function automatic void add(input logic s, input logic b, input logic u, input logic d,
                                input logic rdy, input logic [2:0] st, input logic [2:0] mn,
                                input logic [2:0] bd, input logic [15:0] gn,
                                input logic [1:0] of, input logic v, input logic dsp);
        vecs.push_back('{s, b, u, d, rdy, st, mn, bd, gn, of, v, dsp});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        rst = 1'b1; sel = 1'b0; back = 1'b0; up = 1'b0; down = 1'b0;
        init_done = 1'b0; upd.ready = 1'b0;

        //   s b u d rdy  st mn bd  gain      of v dsp
        add(0,0,1,0,1,   1, 0, 0, 16'h0000, 0,0,0);   // buttons ignored in idle
        add(0,0,0,1,1,   1, 0, 0, 16'h0000, 0,0,0);
        add(0,1,0,0,1,   1, 0, 0, 16'h0000, 0,0,0);
        add(1,0,0,0,1,   2, 0, 0, 16'h0000, 0,0,0);   // enter menu
        add(0,0,1,0,1,   2, 0, 0, 16'h0000, 0,0,0);   // clamp at first item
        add(0,0,0,1,1,   2, 1, 0, 16'h0000, 0,0,0);
        add(0,0,0,1,1,   2, 2, 0, 16'h0000, 0,0,0);
`ifdef EQ_PRESET_EN
        add(0,0,0,1,1,   2, 3, 0, 16'h0000, 0,0,0);
        add(0,0,0,1,1,   2, 4, 0, 16'h0000, 0,0,0);
        add(0,0,0,1,1,   2, 4, 0, 16'h0000, 0,0,0);
        add(0,0,1,0,1,   2, 3, 0, 16'h0000, 0,0,0);
        add(0,0,1,0,1,   2, 2, 0, 16'h0000, 0,0,0);
`else
        add(0,0,0,1,1,   2, 2, 0, 16'h0000, 0,0,0);   // clamp at M_RESET
`endif
        add(0,0,1,0,1,   2, 1, 0, 16'h0000, 0,0,0);
        add(1,0,0,0,1,   5, 1, 0, 16'h0000, 0,0,0);   // offset editor
        add(0,0,1,0,1,   5, 1, 0, 16'h0000, 0,0,0);
        add(0,0,0,1,1,   5, 1, 0, 16'h0000, 1,0,0);
        add(0,0,0,1,1,   5, 1, 0, 16'h0000, 2,0,0);
        add(0,0,0,1,1,   5, 1, 0, 16'h0000, 3,0,0);
        add(0,0,0,1,1,   5, 1, 0, 16'h0000, 3,0,0);   // clamp at OFS_MAX
        add(0,1,1,0,1,   2, 1, 0, 16'h0000, 3,0,0);   // back beats up
        add(1,0,0,0,1,   5, 1, 0, 16'h0000, 3,0,0);
        add(0,0,1,0,1,   5, 1, 0, 16'h0000, 2,0,0);
        add(0,0,0,1,1,   5, 1, 0, 16'h0000, 3,0,0);
        add(1,0,0,0,1,   2, 1, 0, 16'h0000, 3,0,0);
        add(0,0,1,0,1,   2, 0, 0, 16'h0000, 3,0,0);
        add(1,0,0,0,1,   3, 0, 0, 16'h0000, 3,0,0);   // band select
        add(0,0,0,1,1,   3, 0, 0, 16'h0000, 3,0,0);
        add(0,0,1,0,1,   3, 0, 1, 16'h0000, 3,0,0);
        add(0,0,1,0,1,   3, 0, 2, 16'h0000, 3,0,0);
        add(0,1,1,0,1,   2, 0, 2, 16'h0000, 3,0,0);   // up+back: band kept
        add(1,0,0,0,1,   3, 0, 0, 16'h0000, 3,0,0);   // re-entry restarts at band 0
        add(0,0,1,0,1,   3, 0, 1, 16'h0000, 3,0,0);
        add(0,0,1,0,1,   3, 0, 2, 16'h0000, 3,0,0);
        add(1,0,0,0,1,   4, 0, 2, 16'h0000, 3,0,0);   // gain editor, band 2
        add(0,0,0,1,0,   4, 0, 2, 16'hFFFF, 3,1,0);
        add(0,0,0,1,0,   4, 0, 2, 16'hFFFE, 3,1,0);
        add(0,0,0,1,0,   4, 0, 2, 16'hFFFD, 3,1,0);
        add(0,0,0,1,0,   4, 0, 2, 16'hFFFC, 3,1,0);
        add(0,0,0,1,0,   4, 0, 2, 16'hFFFB, 3,1,0);
        add(0,0,0,0,1,   4, 0, 2, 16'hFFFB, 3,0,0);   // transfer drops valid
        add(0,0,1,1,1,   4, 0, 2, 16'hFFFC, 3,1,0);   // up beats down
        add(0,0,0,1,1,   4, 0, 2, 16'hFFFB, 3,1,0);   // transfer + new change: valid held
        add(0,0,0,0,1,   4, 0, 2, 16'hFFFB, 3,0,0);
        add(0,1,0,0,1,   3, 0, 2, 16'hFFFB, 3,0,0);
        add(0,1,0,0,1,   2, 0, 2, 16'hFFFB, 3,0,0);
        add(0,0,0,1,1,   2, 1, 2, 16'hFFFB, 3,0,0);
        add(0,0,0,1,1,   2, 2, 2, 16'hFFFB, 3,0,0);
        add(1,0,0,0,1,   6, 2, 2, 16'h0000, 0,0,1);   // DSP reset pulse
        add(0,0,0,0,1,   2, 2, 2, 16'h0000, 0,0,0);
        add(0,1,0,0,1,   1, 2, 2, 16'h0000, 0,0,0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_state", 32'(state), 32'd0);
        chk("rst_init_start", 32'(init_start), 32'd1);
        chk("rst_menu", 32'(menu), 32'd0);
        chk("rst_band", 32'(band), 32'd0);
        chk("rst_gain", 32'(gain), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_valid", 32'(upd.valid), 32'd0);
        chk("rst_dsp_reset", 32'(dsp_reset), 32'd0);

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(i == 10, 1'b0, i == 20, 1'b0);
            if (state !== 3'd0 || init_start !== 1'b1) bad++;
        end
        chk("init_wait_bad_cycles", 32'(bad), 32'd0);
        init_done = 1'b1;
        cyc(0, 0, 0, 0);
        chk("init_state", 32'(state), 32'd1);
        chk("init_start_drop", 32'(init_start), 32'd0);

        foreach (vecs[i]) begin
            upd.ready = vecs[i].rdy;
            cyc(vecs[i].s, vecs[i].b, vecs[i].u, vecs[i].d);
            chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("row%0d_menu", i), 32'(menu), 32'(vecs[i].mn));
            chk($sformatf("row%0d_band", i), 32'(band), 32'(vecs[i].bd));
            chk($sformatf("row%0d_gain", i), 32'(gain), 32'(vecs[i].gn));
            chk($sformatf("row%0d_offset", i), 32'(offset), 32'(vecs[i].of));
            chk($sformatf("row%0d_valid", i), 32'(upd.valid), 32'(vecs[i].v));
            chk($sformatf("row%0d_dsp_reset", i), 32'(dsp_reset), 32'(vecs[i].dsp));
        end
        upd.ready = 1'b1;

`ifdef EQ_PRESET_EN
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("save_state", 32'(state), 32'd7);
        chk("save_slot0", 32'(band), 32'd0);
        cyc(0, 0, 1, 0);
        chk("save_slot1", 32'(band), 32'd1);
        cyc(1, 0, 0, 0);
        chk("save_done_state", 32'(state), 32'd2);
        repeat (4) cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("pre_load_gain0", 32'(gain), 32'd4);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("load_slot_shown", 32'(band), 32'd1);
        xq.delete();
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 60 && state == 3'd7; k++) begin
            upd.ready = (k % 2 == 0);
            cyc(0, 0, 1, 0);
        end
        chk("load_end_state", 32'(state), 32'd2);
        chk("load_xfer_count", 32'(xq.size()), 32'd8);
        foreach (xq[i]) begin
            chk($sformatf("load_xfer%0d_band", i), 32'(xq[i].band), 32'(i));
            chk($sformatf("load_xfer%0d_gain", i), 32'(xq[i].gain), 32'd0);
        end
        chk("load_gain0", 32'(gain), 32'd0);
        chk("load_valid", 32'(upd.valid), 32'd0);
        upd.ready = 1'b1;
        cyc(0, 1, 0, 0);
`endif

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("ramp_state", 32'(state), 32'd4);
        xq.delete();
        repeat (15) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("ramp_gain_sat", 32'(gain), 32'd12);
        chk("ramp_valid_idle", 32'(upd.valid), 32'd0);
        chk("ramp_xfer_count", 32'(xq.size()), 32'd12);
        foreach (xq[i]) begin
            chk($sformatf("ramp_xfer%0d_band", i), 32'(xq[i].band), 32'd0);
            chk($sformatf("ramp_xfer%0d_gain", i), 32'(xq[i].gain), 32'(i + 1));
        end

        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("hold_band", 32'(band), 32'd1);
        upd.ready = 1'b0;
        xq.delete();
        cyc(0, 0, 1, 0);
        chk("hold_first_gain", 32'(upd.gain), 32'd1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        chk("hold_valid", 32'(upd.valid), 32'd1);
        chk("hold_payload_gain", 32'(upd.gain), 32'd3);
        chk("hold_payload_band", 32'(upd.band), 32'd1);
        chk("hold_no_xfer", 32'(xq.size()), 32'd0);
        upd.ready = 1'b1;
        cyc(0, 0, 0, 0);
        upd.ready = 1'b0;
        chk("hold_valid_clear", 32'(upd.valid), 32'd0);
        cyc(0, 0, 0, 0);
        chk("hold_xfer_count", 32'(xq.size()), 32'd1);
        if (xq.size() > 0) chk("hold_xfer_gain", 32'(xq[0].gain), 32'd3);

        cyc(0, 0, 1, 0);
        chk("midrst_pending", 32'(upd.valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_valid", 32'(upd.valid), 32'd0);
        chk("midrst_init_start", 32'(init_start), 32'd1);
        chk("midrst_band", 32'(band), 32'd0);
        chk("midrst_gain", 32'(gain), 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/eq_menu_ctrl.md
Name: eq_menu_ctrl

Overview:
Parametrised button-driven control FSM for the N-band equaliser path. Sits between the debounced KEY pulses and the DSP. Waits for codec I2C initialisation, then runs a menu for per-band gain, output offset and DSP reset. Gain changes go to the DSP over a valid/ready handshake instead of a static bus, and gains saturate at signed limits.

Parameters:
N_BAND, 8, number of EQ bands; band index 0..N_BAND-1
GAIN_W, 16, width of each signed gain word
GAIN_MAX, 12, upper saturation limit for gain (signed)
GAIN_MIN, -12, lower saturation limit for gain (signed)
OFS_MAX, 3, maximum offset code
N_PRESET, 4, preset slots (used only with EQ_PRESET_EN)

Ports:
i_clk  in  1  system clock (BCLK domain)
i_rst  in  1  reset, asynchronous, active-high
i_select  in  1  select pulse, one cycle
i_back  in  1  back pulse, one cycle
i_up  in  1  up pulse, one cycle
i_down  in  1  down pulse, one cycle
i_init_done  in  1  codec I2C initialisation finished (level)
o_init_start  out  1  request codec initialisation
o_state  out  3  current FSM state code
o_menu  out  3  highlighted menu item
o_band  out  $clog2(N_BAND)  selected band
o_gain  out  GAIN_W  signed gain of selected band
o_offset  out  $clog2(OFS_MAX+1)  offset code
o_upd_valid  out  1  gain update pending
o_upd_band  out  $clog2(N_BAND)  band of pending update
o_upd_gain  out  GAIN_W  gain of pending update
i_upd_ready  in  1  DSP accepts update
o_dsp_reset  out  1  one-cycle DSP clear pulse

Behaviour:
- Reset values: state S_INIT, o_init_start=1, menu=M_EQ(0), band=0, all gains=0, offset=0, o_upd_valid=0, upd_band/upd_gain=0, o_dsp_reset=0.
- State codes: S_INIT=0, S_IDLE=1, S_MENU=2, S_BAND_SEL=3, S_SET_GAIN=4, S_SET_OFFSET=5, S_RESET_DSP=6, S_PRESET=7.
- Menu item codes: M_EQ=0, M_OFFSET=1, M_RESET=2, M_LOAD=3, M_SAVE=4.
- Button priority when several pulses arrive in one cycle: back > select > up > down. Only the highest-priority pulse acts.
- All registered outputs change one cycle after the causing pulse.
- S_INIT: o_init_start=1. When i_init_done=1, go to S_IDLE and drop o_init_start. No other input acts.
- S_IDLE: select → S_MENU with menu=M_EQ. Other buttons are ignored.
- S_MENU:
  - up/down step the menu, clamped at 0 and at the last item (no wrap). The last item is M_RESET, or M_SAVE when the preset feature is enabled.
  - back → S_IDLE.
  - select on M_EQ → S_BAND_SEL with band=0.
  - select on M_OFFSET → S_SET_OFFSET.
  - select on M_RESET → S_RESET_DSP.
- S_BAND_SEL:
  - up/down change band, clamped to 0..N_BAND-1.
  - select → S_SET_GAIN.
  - back → S_MENU; band is kept.
- S_SET_GAIN:
  - up adds 1 to gain[band], saturating at GAIN_MAX.
  - down subtracts 1 from gain[band], saturating at GAIN_MIN.
  - Arithmetic is signed GAIN_W. Saturation is compared before writing, so no wrap is possible.
  - A press that leaves the gain unchanged (already at a limit) issues no update.
  - select or back → S_BAND_SEL.
- Update handshake:
  - Every actual gain change loads upd_band/upd_gain and sets o_upd_valid.
  - Transfer occurs on a cycle where valid && ready; valid clears the next cycle unless a new change lands in that same cycle.
  - A new change while valid is still pending overwrites the payload (latest wins) and valid stays high.
  - Payload is stable while valid && !ready, except for such an overwrite.
- S_SET_OFFSET:
  - down increments offset, clamped at OFS_MAX.
  - up decrements offset, clamped at 0.
  - select or back → S_MENU.
  - A back in the same cycle as up/down wins, and offset is unchanged.
- S_RESET_DSP: lasts exactly one cycle. o_dsp_reset=1, all gains=0, offset=0, any pending update is dropped (valid=0), then → S_MENU.
- Reset mid-operation: asynchronous return to the reset values above. A pending update is lost; the DSP is expected to be reset by the same i_rst.

Optional Feature:
EQ_PRESET_EN:
- Defined:
  - Adds N_PRESET×N_BAND gain slots (reset to 0), a slot index, and menu items M_LOAD/M_SAVE.
  - Selecting either item → S_PRESET; o_band shows the slot index there. up/down pick the slot, clamped. back → S_MENU.
  - Select on SAVE copies all gains into the slot in one cycle, then → S_MENU.
  - Select on LOAD copies the slot into the gains. It then issues one update per band, 0..N_BAND-1, each waiting for its own handshake, then → S_MENU. Buttons are ignored during the load walk.
- Undefined: the menu has 3 items, S_PRESET is unreachable and no slot storage is synthesised.

Test Plan:
- Reset, hold i_init_done=0 for 50 cycles, then 1 → o_init_start=1 throughout, then 0; o_state 0→1.
- select, select, select (enter band 0 gain), up ×15 with i_upd_ready=1 → gain[0]=12; exactly 12 update transfers, each with band=0 and gains 1..12.
- In S_SET_GAIN with i_upd_ready=0, press up 3× from 0 → valid held, payload gain=3; raise ready for 1 cycle → one transfer, then valid=0.
- up+back in the same cycle in S_BAND_SEL → S_MENU, band unchanged.
- Set gain[2]=-5 and offset=3, then menu M_RESET select → o_dsp_reset high exactly 1 cycle, gains=0, offset=0, state=S_MENU.
- With EQ_PRESET_EN: save slot 1, change gain[0] to 4, load slot 1 with ready toggling 1/0 → N_BAND transfers in band order, gain[0]=0 afterwards.
